// File: rtl/des_key_sched_if.sv
// DES key schedule port bundle: key handshake in,
// subkey stream out, plus status.
interface des_key_sched_if;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] sk_out;
  logic [4:0]  sk_idx;
  logic        sk_valid;
  logic        sk_ready;
  logic        busy;
  logic        done;

  modport master (
    output key_in, decrypt, key_valid, sk_ready,
    input  key_ready, sk_out, sk_idx, sk_valid,
    input  busy, done
  );

  modport slave (
    input  key_in, decrypt, key_valid, sk_ready,
    output key_ready, sk_out, sk_idx, sk_valid,
    output busy, done
  );
endinterface

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 on load, one
// C/D rotation per accepted beat, PC-2 per subkey.
module des_key_sched (
  input logic            clk,
  input logic            rst,
  des_key_sched_if.slave ks
);
  typedef enum logic [1:0] {
    IDLE, LOAD, RUN
  } state_t;

  localparam logic [0:55][6:0] PC1 = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [0:47][5:0] PC2 = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Bit n of the FIPS numbering sits at vector index width-n.
  function automatic logic [55:0] pc1(
    input logic [63:0] k
  );
    logic [55:0] r;
    logic [5:0]  j;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      j = 6'(7'd64 - PC1[i]);
      r[55-i] = k[j];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(
    input logic [55:0] cd
  );
    logic [47:0] r;
    logic [5:0]  j;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      j = 6'd56 - PC2[i];
      r[47-i] = cd[j];
    end
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one, all others by two.
  function automatic logic two_step(
    input logic [4:0] r
  );
    return !(r == 5'd1 || r == 5'd2 ||
             r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [27:0] rl(
    input logic [27:0] v,
    input logic        two
  );
    return two ? {v[25:0], v[27:26]}
               : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rr(
    input logic [27:0] v,
    input logic        two
  );
    return two ? {v[1:0], v[27:2]}
               : {v[0], v[27:1]};
  endfunction

  state_t      state;
  logic [55:0] cd_q;
  logic        dec_q;
  logic [47:0] sk_q;
  logic [4:0]  idx_q;
  logic        vld_q;
  logic        done_q;

  logic [55:0] cd_l1;
  logic [55:0] cd_nx;
  logic [4:0]  idx_nx;
  logic        step2;
  logic        last;

  // Next-round C/D and index for both directions.
  always_comb begin
    cd_l1  = {rl(cd_q[55:28], 1'b0),
              rl(cd_q[27:0], 1'b0)};
    step2  = dec_q ? two_step(idx_q)
                   : two_step(idx_q + 5'd1);
    cd_nx  = dec_q ? {rr(cd_q[55:28], step2),
                      rr(cd_q[27:0], step2)}
                   : {rl(cd_q[55:28], step2),
                      rl(cd_q[27:0], step2)};
    idx_nx = dec_q ? idx_q - 5'd1 : idx_q + 5'd1;
    last   = dec_q ? (idx_q == 5'd1)
                   : (idx_q == 5'd16);
  end

  // Control FSM with registered subkey stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cd_q   <= '0;
      dec_q  <= 1'b0;
      sk_q   <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ks.key_valid) begin
            cd_q  <= pc1(ks.key_in);
            dec_q <= ks.decrypt;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (dec_q) begin
            sk_q  <= pc2(cd_q);
            idx_q <= 5'd16;
          end else begin
            cd_q  <= cd_l1;
            sk_q  <= pc2(cd_l1);
            idx_q <= 5'd1;
          end
          vld_q <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          if (vld_q && ks.sk_ready) begin
            if (last) begin
              vld_q  <= 1'b0;
              idx_q  <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              cd_q  <= cd_nx;
              sk_q  <= pc2(cd_nx);
              idx_q <= idx_nx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ks.key_ready = (state == IDLE);
  assign ks.busy      = (state != IDLE);
  assign ks.sk_out    = sk_q;
  assign ks.sk_idx    = idx_q;
  assign ks.sk_valid  = vld_q;
  assign ks.done      = done_q;
endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the
// FIPS 46-3 worked key 133457799BBCDFF1.
module tb_des_key_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR = 64'h0101010101010101;

  logic [47:0] ktab [1:16];

  des_key_sched_if ks_if ();

  des_key_sched dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks_if)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic check_rst_vals(input string tag);
    check({tag, "_krdy"}, 64'(ks_if.key_ready), 64'd1);
    check({tag, "_sk"},   64'(ks_if.sk_out), 64'd0);
    check({tag, "_idx"},  64'(ks_if.sk_idx), 64'd0);
    check({tag, "_vld"},  64'(ks_if.sk_valid), 64'd0);
    check({tag, "_busy"}, 64'(ks_if.busy), 64'd0);
    check({tag, "_done"}, 64'(ks_if.done), 64'd0);
  endtask

  // stall: random sk_ready; abort_at: reset after
  // that many beats; inject: stray key at T+5.
  task automatic run_stream(
    input logic [63:0] key,
    input logic        dec,
    input bit          stall,
    input int          abort_at,
    input bit          inject
  );
    int          cyc;
    int          beats;
    int          guard;
    int          exp_idx;
    bit          held;
    logic [47:0] p_out;
    logic [4:0]  p_idx;
    cyc     = 0;
    beats   = 0;
    guard   = 0;
    exp_idx = dec ? 16 : 1;
    held    = 1'b0;
    p_out   = '0;
    p_idx   = '0;
    @(negedge clk);
    check("t0_krdy", 64'(ks_if.key_ready), 64'd1);
    ks_if.key_in    = key;
    ks_if.decrypt   = dec;
    ks_if.key_valid = 1'b1;
    @(negedge clk);
    cyc = 1;
    ks_if.key_valid = 1'b0;
    ks_if.decrypt   = ~dec;
    check("t1_busy", 64'(ks_if.busy), 64'd1);
    check("t1_krdy", 64'(ks_if.key_ready), 64'd0);
    while (beats < 16 && guard < 400) begin
      @(negedge clk);
      cyc++;
      guard++;
      if (inject && cyc == 5) begin
        ks_if.key_in    = 64'h0123456789ABCDEF;
        ks_if.key_valid = 1'b1;
        check("ign_krdy", 64'(ks_if.key_ready), 64'd0);
      end else begin
        ks_if.key_valid = 1'b0;
      end
      check("done_early", 64'(ks_if.done), 64'd0);
      if (!stall)
        check("vld_ontime", 64'(ks_if.sk_valid), 64'd1);
      if (held) begin
        check("stall_sk", 64'(ks_if.sk_out), 64'(p_out));
        check("stall_idx", 64'(ks_if.sk_idx), 64'(p_idx));
      end
      if (ks_if.sk_valid) begin
        check("idx", 64'(ks_if.sk_idx), 64'(exp_idx));
        check("sk", 64'(ks_if.sk_out),
              64'(ktab[exp_idx]));
      end
      ks_if.sk_ready = stall ? 1'($urandom_range(0, 1))
                             : 1'b1;
      held  = ks_if.sk_valid && !ks_if.sk_ready;
      p_out = ks_if.sk_out;
      p_idx = ks_if.sk_idx;
      if (ks_if.sk_valid && ks_if.sk_ready) begin
        beats++;
        exp_idx = dec ? exp_idx - 1 : exp_idx + 1;
      end
      if (abort_at != 0 && beats == abort_at)
        break;
    end
    ks_if.key_valid = 1'b0;
    if (guard >= 400)
      check("timeout", 64'd0, 64'd1);
    if (abort_at != 0) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_rst_vals("midrst");
      @(negedge clk);
      check("midrst_nodone", 64'(ks_if.done), 64'd0);
      check("midrst_idle", 64'(ks_if.busy), 64'd0);
    end else begin
      @(negedge clk);
      cyc++;
      if (!stall)
        check("done_cyc", 64'(cyc), 64'd18);
      check("done", 64'(ks_if.done), 64'd1);
      check("end_krdy", 64'(ks_if.key_ready), 64'd1);
      check("end_busy", 64'(ks_if.busy), 64'd0);
      check("end_vld", 64'(ks_if.sk_valid), 64'd0);
      check("end_idx", 64'(ks_if.sk_idx), 64'd0);
      @(negedge clk);
      check("done_pulse", 64'(ks_if.done), 64'd0);
      check("stay_idle", 64'(ks_if.key_ready), 64'd1);
    end
  endtask

  initial begin
    ktab[1]  = 48'h1B02EFFC7072;
    ktab[2]  = 48'h79AED9DBC9E5;
    ktab[3]  = 48'h55FC8A42CF99;
    ktab[4]  = 48'h72ADD6DB351D;
    ktab[5]  = 48'h7CEC07EB53A8;
    ktab[6]  = 48'h63A53E507B2F;
    ktab[7]  = 48'hEC84B7F618BC;
    ktab[8]  = 48'hF78A3AC13BFB;
    ktab[9]  = 48'hE0DBEBEDE781;
    ktab[10] = 48'hB1F347BA464F;
    ktab[11] = 48'h215FD3DED386;
    ktab[12] = 48'h7571F59467E9;
    ktab[13] = 48'h97C5D1FABA41;
    ktab[14] = 48'h5F43B7F2E73A;
    ktab[15] = 48'hBF918D3D3F0A;
    ktab[16] = 48'hCB3D8B0E17F5;

    ks_if.key_in    = '0;
    ks_if.decrypt   = 1'b0;
    ks_if.key_valid = 1'b0;
    ks_if.sk_ready  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_rst_vals("reset");
    rst = 1'b0;

    run_stream(KEY, 1'b0, 1'b0, 0, 1'b0);
    run_stream(KEY, 1'b1, 1'b0, 0, 1'b0);
    run_stream(KEY, 1'b0, 1'b1, 0, 1'b0);
    run_stream(KEY, 1'b1, 1'b1, 0, 1'b0);
    run_stream(KEY, 1'b0, 1'b0, 0, 1'b1);
    run_stream(KEY, 1'b0, 1'b0, 7, 1'b0);
    run_stream(KEY, 1'b0, 1'b0, 0, 1'b0);
    run_stream(KEY, 1'b1, 1'b0, 7, 1'b0);
    run_stream(KEY ^ PAR, 1'b0, 1'b0, 0, 1'b0);
    run_stream(KEY ^ PAR, 1'b1, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/des_key_sched.md
# des_key_sched

Iterative DES key-schedule controller. Accepts a 64-bit key over a valid/ready handshake and applies PC-1. It then sequences the per-round C/D rotations, one round per accepted output beat, instead of computing cumulative shifts in parallel. It emits the 16 PC-2 subkeys as a back-pressurable stream: K1..K16 in encrypt order or K16..K1 in decrypt order. It sits between the key register and the DES round datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_in  in  64  key, FIPS 46-3 bit numbering [1:64] (bit 1 = MSB); parity bits 8,16,…,64 ignored
- decrypt  in  1  0 = emit K1..K16; 1 = emit K16..K1; sampled with key
- key_valid  in  1  key_in/decrypt valid
- key_ready  out  1  high only in IDLE
- sk_out  out  48  current subkey, PC-2 ordering [1:48]
- sk_idx  out  5  round number of sk_out (1..16); 0 when sk_valid low
- sk_valid  out  1  subkey valid
- sk_ready  in  1  consumer accepts sk_out
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse after the 16th subkey is accepted

## Operation
- Round shift table s(r), r = 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- FSM states: IDLE, LOAD, RUN.
- IDLE: key_ready = 1. On key_valid, register PC-1(key_in) into C (bits 1..28) and D (bits 29..56), latch decrypt, and go to LOAD.
- LOAD, one cycle:
  - Encrypt: rotate C and D left by s(1), register PC-2(C,D) into sk_out, set sk_idx = 1.
  - Decrypt: no rotation (cumulative 28 = identity), register PC-2(C0,D0), set sk_idx = 16.
  - Set sk_valid = 1 and go to RUN.
- RUN: sk_out, sk_idx and sk_valid are held stable while sk_valid && !sk_ready. On each handshake (sk_valid && sk_ready):
  - Encrypt, if sk_idx < 16: rotate C and D left by s(sk_idx+1), register the new PC-2 and sk_idx+1.
  - Decrypt, if sk_idx > 1: rotate C and D right by s(sk_idx), register the new PC-2 and sk_idx−1.
  - On the final beat (encrypt sk_idx = 16, decrypt sk_idx = 1): clear sk_valid, set sk_idx = 0, pulse done, go to IDLE.
- Rotations are single-step by 1 or 2 positions on 28-bit registers; bits wrap from position 1 to position 28 and back.
- key_valid is ignored while busy; no queuing.
- There is no abort port. rst is the only way to cancel a schedule in progress.

## Timing
- Reset values: key_ready = 1, sk_out = 0, sk_idx = 0, sk_valid = 0, busy = 0, done = 0. C, D and the decrypt latch are cleared.
- Reset asserted mid-schedule: the next cycle shows the reset values; any partial stream is abandoned and no done pulse is issued.
- Key accepted at cycle T:
  - T+1: busy = 1, key_ready = 0 (LOAD).
  - T+2: sk_valid = 1 with the first subkey.
- With sk_ready held high, 16 beats appear on consecutive cycles T+2..T+17.
- done = 1 at T+18. In that same cycle key_ready = 1 and busy = 0.
- A new key may be accepted at T+18. Minimum key-to-key period is 18 cycles.
- Each cycle of sk_ready low adds one cycle of latency. No subkey is skipped or duplicated.
- sk_ready high while sk_valid is low has no effect.

## Test plan
- **Encrypt, FIPS vector:**
  - Stimulus: key 0x133457799BBCDFF1, decrypt = 0, sk_ready = 1.
  - Required: sk_out = 0x1B02EFFC7072 with sk_idx = 1 at T+2; 0xCB3D8B0E17F5 with sk_idx = 16 at T+17; done at T+18.
- **Decrypt order:**
  - Stimulus: same key, decrypt = 1.
  - Required: first beat 0xCB3D8B0E17F5 with sk_idx = 16; last beat 0x1B02EFFC7072 with sk_idx = 1; the 16 values are the exact reverse of the encrypt run.
- **Back-pressure:**
  - Stimulus: toggle sk_ready in a pseudo-random pattern.
  - Required: sk_out and sk_idx stable while stalled; exactly 16 beats in order; done only after the 16th handshake.
- **Busy ignore:**
  - Stimulus: pulse key_valid with a different key at T+5.
  - Required: key_ready = 0 at T+5; the stream is unchanged; the second key is accepted only once back in IDLE.
- **Reset mid-run:**
  - Stimulus: assert rst after the 7th beat.
  - Required: all outputs at reset values the next cycle; no done pulse; a fresh key then produces a full, correct 16-beat stream.
- **Parity independence:**
  - Stimulus: key 0x133457799BBCDFF1 with all parity bits inverted (XOR 0x0101010101010101).
  - Required: identical 16 subkeys.
